// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, LSU/MUL results queue in a FIFO,
// and a busy scoreboard tracks pending long-latency writes. Optional macro: WB_LSU_BYPASS_EN.
module writeback_arbiter #(
   parameter int M     = 5,
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [M-1:0]             alu_rd,
   input  logic [N-1:0]             alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [M-1:0]             lsu_rd,
   input  logic [N-1:0]             lsu_data,
   input  logic                     issue_valid,
   input  logic [M-1:0]             issue_rd,
   output logic [(1<<M)-1:0]        busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     w_en,
   output logic [M-1:0]             rd,
   output logic [N-1:0]             din
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int NREG = 1 << M;

   logic [M-1:0]    mem_rd_q   [DEPTH];
   logic [M-1:0]    mem_rd_d   [DEPTH];
   logic [N-1:0]    mem_data_q [DEPTH];
   logic [N-1:0]    mem_data_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            w_en_q, w_en_d;
   logic [M-1:0]    rd_q, rd_d;
   logic [N-1:0]    din_q, din_d;

   logic            alu_eff;
   logic            fifo_empty;
   logic            push_fire;
   logic            bypass;
   logic            push;
   logic            pop;
   logic [M-1:0]    head_rd;
   logic [N-1:0]    head_data;

   assign alu_eff    = alu_valid && (alu_rd != '0);
   assign fifo_empty = (count_q == '0);
   // Ready looks only at occupancy, never at a same-cycle pop.
   assign lsu_ready  = (count_q < CW'(DEPTH));
   assign push_fire  = lsu_valid && lsu_ready;
   assign head_rd    = mem_rd_q[rd_ptr_q];
   assign head_data  = mem_data_q[rd_ptr_q];
   assign pop        = !alu_eff && !fifo_empty;

`ifdef WB_LSU_BYPASS_EN
   assign bypass = fifo_empty && !alu_eff && push_fire;
`else
   assign bypass = 1'b0;
`endif

   assign push = push_fire && !bypass;

   always_comb begin
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         mem_rd_d[wr_ptr_q]   = lsu_rd;
         mem_data_d[wr_ptr_q] = lsu_data;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Write-port selection; rd/din only move when a real write is issued.
   always_comb begin
      w_en_d = 1'b0;
      rd_d   = rd_q;
      din_d  = din_q;
      if (alu_eff) begin
         w_en_d = 1'b1;
         rd_d   = alu_rd;
         din_d  = alu_data;
      end else if (pop) begin
         if (head_rd != '0) begin
            w_en_d = 1'b1;
            rd_d   = head_rd;
            din_d  = head_data;
         end
      end else if (bypass && (lsu_rd != '0)) begin
         w_en_d = 1'b1;
         rd_d   = lsu_rd;
         din_d  = lsu_data;
      end
   end

   // Clears are applied before the set so a same-cycle issue to the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (bypass) begin
         busy_d[lsu_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= '0;
         w_en_q   <= 1'b0;
         rd_q     <= '0;
         din_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         w_en_q   <= w_en_d;
         rd_q     <= rd_d;
         din_q    <= din_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
   end

   assign busy       = busy_q;
   assign fifo_count = count_q;
   assign w_en       = w_en_q;
   assign rd         = rd_q;
   assign din        = din_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter; optional WB_LSU_BYPASS_EN selects bypass latency expectations.
module tb_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic [2:0]  fifo_count;
   logic        w_en;
   logic [4:0]  rd;
   logic [31:0] din;

   int checks = 0;
   int errors = 0;

   writeback_arbiter #(.M(5), .N(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .busy       (busy),
      .fifo_count (fifo_count),
      .w_en       (w_en),
      .rd         (rd),
      .din        (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; outputs are then sampled and inputs changed away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0; issue_valid = 0; issue_rd = 0;
      step(); step();
      rst = 1'b0;
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got %0b want 0", w_en); end
      checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd); end
      checks++; if (din !== 32'd0) begin errors++; $display("FAIL reset_din got %h want 0", din); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", lsu_ready); end
   endtask

   task automatic test_alu();
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h0000_0005;
      step();
      alu_valid = 0;
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL alu_w_en got %0b want 1", w_en); end
      checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", rd); end
      checks++; if (din !== 32'h5) begin errors++; $display("FAIL alu_din got %h want 5", din); end
      step();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL alu_w_en_off got %0b want 0", w_en); end
      checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd_hold got %0d want 5", rd); end
   endtask

   task automatic test_alu_rd0();
      alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
      step();
      alu_valid = 0;
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL rd0_w_en got %0b want 0", w_en); end
      checks++; if (din !== 32'h5) begin errors++; $display("FAIL rd0_din got %h want 5", din); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rd0_count got %0d want 0", fifo_count); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rd0_busy got %h want 0", busy); end
   endtask

   task automatic test_lsu_latency();
      issue_valid = 1; issue_rd = 5'd7;
      step();
      issue_valid = 0;
      checks++; if (busy !== 32'h80) begin errors++; $display("FAIL lat_busy_set got %h want 80", busy); end
      lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h13;
      step();
      lsu_valid = 0;
`ifdef WB_LSU_BYPASS_EN
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL lat_w_en got %0b want 1", w_en); end
      checks++; if (rd !== 5'd7) begin errors++; $display("FAIL lat_rd got %0d want 7", rd); end
      checks++; if (din !== 32'h13) begin errors++; $display("FAIL lat_din got %h want 13", din); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL lat_busy_clr got %h want 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lat_count got %0d want 0", fifo_count); end
`else
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL lat_w_en_early got %0b want 0", w_en); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL lat_count1 got %0d want 1", fifo_count); end
      checks++; if (busy !== 32'h80) begin errors++; $display("FAIL lat_busy_held got %h want 80", busy); end
      step();
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL lat_w_en got %0b want 1", w_en); end
      checks++; if (rd !== 5'd7) begin errors++; $display("FAIL lat_rd got %0d want 7", rd); end
      checks++; if (din !== 32'h13) begin errors++; $display("FAIL lat_din got %h want 13", din); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL lat_busy_clr got %h want 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lat_count0 got %0d want 0", fifo_count); end
`endif
      step();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL lat_w_en_off got %0b want 0", w_en); end
   endtask

   task automatic test_fill_and_drain();
      logic [31:0] exp_busy;
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
      for (int i = 1; i <= 4; i++) begin
         lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'(i * 32'h11);
         issue_valid = 1; issue_rd = 5'(i);
         step();
         checks++; if (w_en !== 1'b1 || rd !== 5'd9 || din !== 32'h99) begin
            errors++; $display("FAIL fill_alu_write%0d got w_en=%0b rd=%0d din=%h want 1/9/99", i, w_en, rd, din);
         end
      end
      issue_valid = 0;
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", fifo_count); end
      checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", lsu_ready); end
      checks++; if (busy !== 32'h1E) begin errors++; $display("FAIL fill_busy got %h want 1e", busy); end
      // Full FIFO: offer rd=5 while the first pop happens; it must wait one cycle.
      lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h55;
      alu_valid = 0;
      step();
      checks++; if (w_en !== 1'b1 || rd !== 5'd1 || din !== 32'h11) begin
         errors++; $display("FAIL drain1 got w_en=%0b rd=%0d din=%h want 1/1/11", w_en, rd, din);
      end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", fifo_count); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL ready_back got %0b want 1", lsu_ready); end
      checks++; if (busy !== 32'h1C) begin errors++; $display("FAIL drain1_busy got %h want 1c", busy); end
      step();
      lsu_valid = 0;
      checks++; if (w_en !== 1'b1 || rd !== 5'd2 || din !== 32'h22) begin
         errors++; $display("FAIL drain2 got w_en=%0b rd=%0d din=%h want 1/2/22", w_en, rd, din);
      end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL push_pop_count got %0d want 3", fifo_count); end
      exp_busy = 32'h18;
      for (int i = 3; i <= 5; i++) begin
         step();
         checks++; if (w_en !== 1'b1 || rd !== 5'(i) || din !== 32'(i * 32'h11)) begin
            errors++; $display("FAIL drain%0d got w_en=%0b rd=%0d din=%h want 1/%0d/%h", i, w_en, rd, din, i, i * 32'h11);
         end
         checks++; if (fifo_count !== 3'(5 - i)) begin errors++; $display("FAIL drain%0d_count got %0d want %0d", i, fifo_count, 5 - i); end
         if (i < 5) exp_busy[i] = 1'b0;
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL drain%0d_busy got %h want %h", i, busy, exp_busy); end
      end
      step();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b want 0", w_en); end
   endtask

   task automatic test_pop_rd0();
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
      lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h77;
      step();
      alu_valid = 0; lsu_valid = 0;
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL pop0_count1 got %0d want 1", fifo_count); end
      step();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL pop0_w_en got %0b want 0", w_en); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pop0_count0 got %0d want 0", fifo_count); end
   endtask

   task automatic test_reset_mid();
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
      for (int i = 2; i <= 4; i++) begin
         lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'hA0 + 32'(i);
         issue_valid = (i == 2); issue_rd = 5'd2;
         step();
      end
      lsu_valid = 0; issue_valid = 0;
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count3 got %0d want 3", fifo_count); end
      checks++; if (busy !== 32'h4) begin errors++; $display("FAIL mid_busy2 got %h want 4", busy); end
      alu_valid = 0; rst = 1;
      step();
      rst = 0;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count0 got %0d want 0", fifo_count); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mid_busy0 got %h want 0", busy); end
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL mid_w_en got %0b want 0", w_en); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", lsu_ready); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL mid_stale_write%0d got w_en=%0b rd=%0d want 0", i, w_en, rd); end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_alu_rd0();
      test_lsu_latency();
      test_fill_and_drain();
      test_pop_rd0();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the CPU register file: merges results from the single-cycle ALU path and the multi-cycle LSU/MUL path onto the register file's single write port (w_en, rd, din).
- Buffers long-latency results in a small FIFO and tracks pending destination registers in a busy scoreboard, so decode can detect RAW hazards before it reads rs1/rs2.

Parameters:
- M, 5, register address width (2^M registers).
- N, 32, data width.
- DEPTH, 4, LSU result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_rd  in  M  ALU destination register.
- alu_data  in  N  ALU result.
- lsu_valid  in  1  LSU/MUL result offered.
- lsu_ready  out  1  FIFO can accept the result.
- lsu_rd  in  M  LSU destination register.
- lsu_data  in  N  LSU result.
- issue_valid  in  1  a long-latency instruction issued this cycle.
- issue_rd  in  M  its destination register.
- busy  out  2^M  scoreboard; bit i set = register i has a pending long-latency write.
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.
- w_en  out  1  register-file write enable (registered).
- rd  out  M  register-file write address (registered).
- din  out  N  register-file write data (registered).

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset:
  - w_en=0, rd=0, din=0, busy=0, fifo_count=0, FIFO pointers cleared.
  - lsu_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered entries and clears busy. No write is issued in the reset cycle.
- Effective ALU request: alu_valid && alu_rd!=0. An ALU result with rd=0 is dropped and does not block the FIFO.
- Push:
  - lsu_ready = (fifo_count < DEPTH), combinational from the count only. It does not depend on a same-cycle pop.
  - A transfer occurs when lsu_valid && lsu_ready; lsu_rd/lsu_data are captured at that edge.
  - The LSU must hold lsu_valid, lsu_rd and lsu_data stable until the transfer occurs.
- Arbitration, per cycle:
  - The effective ALU request has strict priority and is written.
  - Otherwise, if the FIFO is non-empty, the head is popped.
  - The selected entry is registered to w_en/rd/din at the next edge, so the write is visible one cycle after selection.
  - A popped head with rd=0 is consumed with w_en=0.
  - With no selection, w_en=0; rd/din hold their previous values.
- Latency, without the optional feature:
  - ALU: w_en high in the cycle after alu_valid.
  - LSU: accepted at edge k, entry visible at the FIFO head in cycle k+1, written at edge k+1 when not preempted by the ALU.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged. When full, there is no push that cycle even if a pop occurs.
- FIFO pointers wrap modulo DEPTH. Order is strictly FIFO.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the edge.
  - A FIFO pop with rd=r clears busy[r].
  - Same-cycle set and clear of the same r: set wins.
  - ALU writes never touch busy.
  - busy[0] is always 0.
- ALU starvation: a continuous ALU stream may starve the FIFO indefinitely. The pipeline must stall ALU issue when it needs a drain; this block provides no fairness.

Optional Feature:
- Macro: WB_LSU_BYPASS_EN.
- Defined:
  - Bypass condition: FIFO empty, no effective ALU request, and an LSU transfer occurs.
  - Under that condition the LSU result goes directly to w_en/rd/din at the same edge and is not pushed.
  - busy for that rd is cleared at the same edge, and LSU latency drops to 1 cycle.
  - In that cycle lsu_ready is still count-based (=1 since the FIFO is empty).
- Undefined: every LSU result passes through the FIFO, with 2-cycle minimum latency.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0x0000_0005 -> next cycle w_en=1, rd=5, din=5; the following cycle w_en=0.
- alu_rd=0, alu_data=0xDEAD_BEEF -> w_en stays 0; no state change.
- issue rd=7, then LSU rd=7, data=0x13 while the ALU is idle -> busy[7]=1 until the write. w_en=1 with rd=7, din=0x13 2 cycles after acceptance (1 with WB_LSU_BYPASS_EN); busy[7]=0 after.
- Push 4 LSU entries (rd 1..4, data 0x11..0x44) while alu_valid=1 continuously with rd=9 -> fifo_count=4, lsu_ready=0, only rd=9 written. Drop alu_valid -> rd 1,2,3,4 written in order on 4 consecutive cycles, lsu_ready returns to 1.
- FIFO full plus pop and lsu_valid in the same cycle -> no push (lsu_ready=0), count goes 4->3. Push accepted the next cycle.
- Assert rst with 3 entries buffered and busy[2]=1 -> next cycle fifo_count=0, busy=0, w_en=0. The old entries are never written.
